// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// and the select/operation codes driven onto the datapath.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_e;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode from the FSM's aluop and the instruction funct fields;
// shared with the single-cycle datapath.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      default: begin
        case (funct3)
          // op5 separates R-type from addi, which never subtracts
          3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM sequencing the shared ALU/immediate datapath of the
// multicycle RV32I core.
//
// state    | meaning
// FETCH    | read instruction, PC <= PC+4
// DECODE   | decode opcode, precompute branch target
// MEMADR   | rs1 + imm load/store address
// MEMREAD  | read data memory
// MEMWB    | write load data to rd
// MEMWRITE | write rs2 to data memory
// EXECR    | register-register ALU op
// EXECI    | register-immediate ALU op
// ALUWB    | write ALU result to rd
// BEQ      | compare, branch on zero
// JAL      | link value, PC <= target
// HALT     | stopped on illegal opcode
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [1:0] immsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic [1:0] resultsrc,
  output logic       adrsrc,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       halted
);

  state_e     state_q, state_d, out_state;
  logic [1:0] aluop;
  logic       ir_en, reg_en, mem_en, pcupdate, branch;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  // During reset the datapath sees FETCH selects so it settles before release
  always_comb begin
    out_state = reset ? S_FETCH : state_q;
    immsrc    = IMM_I;
    alusrca   = SRCA_PC;
    alusrcb   = SRCB_RS2;
    resultsrc = RES_ALUOUT;
    adrsrc    = 1'b0;
    aluop     = ALUOP_ADD;
    ir_en     = 1'b0;
    reg_en    = 1'b0;
    mem_en    = 1'b0;
    pcupdate  = 1'b0;
    branch    = 1'b0;
    case (out_state)
      S_FETCH: begin
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALU;
        ir_en     = 1'b1;
        pcupdate  = 1'b1;
      end
      S_DECODE: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
        immsrc  = IMM_B;
      end
      S_MEMADR: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
        immsrc  = op[5] ? IMM_S : IMM_I;
      end
      S_MEMREAD:  adrsrc = 1'b1;
      S_MEMWB: begin
        resultsrc = RES_DATA;
        reg_en    = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc = 1'b1;
        mem_en = 1'b1;
      end
      S_EXECR: begin
        alusrca = SRCA_RS1;
        aluop   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB:    reg_en = 1'b1;
      S_BEQ: begin
        alusrca = SRCA_RS1;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
      end
      S_JAL: begin
        alusrca  = SRCA_OLDPC;
        alusrcb  = SRCB_FOUR;
        pcupdate = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .alucontrol (alucontrol)
  );

  assign irwrite  = ir_en  & ~reset;
  assign regwrite = reg_en & ~reset;
  assign memwrite = mem_en & ~reset;
  assign pcwrite  = (pcupdate | (branch & zero)) & ~reset;
  assign halted   = (out_state == S_HALT);

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: two controllers (halt / skip on illegal opcode) driven
// in lockstep and compared cycle by cycle against a per-instruction model.
module tb_multicycle_controller;

  typedef struct packed {
    logic [1:0] immsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic [2:0] aluc;
    logic       adrsrc;
    logic       ir;
    logic       pc;
    logic       rw;
    logic       mw;
    logic       halted;
  } obs_t;

  typedef struct packed {
    obs_t       v;
    logic [5:0] care;
  } cyc_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;

  logic [1:0] immsrc_h, alusrca_h, alusrcb_h, resultsrc_h;
  logic [2:0] aluc_h;
  logic       adrsrc_h, ir_h, pc_h, rw_h, mw_h, halted_h;
  logic [1:0] immsrc_s, alusrca_s, alusrcb_s, resultsrc_s;
  logic [2:0] aluc_s;
  logic       adrsrc_s, ir_s, pc_s, rw_s, mw_s, halted_s;
  obs_t       obs_h, obs_s;

  int n_checks = 0;
  int n_fail   = 0;
  cyc_t exp_q[$];

  always #5 clk = ~clk;

  multicycle_controller #(.ILLEGAL_HALT(1'b1)) dut_h (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .immsrc(immsrc_h), .alusrca(alusrca_h), .alusrcb(alusrcb_h), .alucontrol(aluc_h),
    .resultsrc(resultsrc_h), .adrsrc(adrsrc_h), .irwrite(ir_h), .pcwrite(pc_h),
    .regwrite(rw_h), .memwrite(mw_h), .halted(halted_h)
  );

  multicycle_controller #(.ILLEGAL_HALT(1'b0)) dut_s (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .immsrc(immsrc_s), .alusrca(alusrca_s), .alusrcb(alusrcb_s), .alucontrol(aluc_s),
    .resultsrc(resultsrc_s), .adrsrc(adrsrc_s), .irwrite(ir_s), .pcwrite(pc_s),
    .regwrite(rw_s), .memwrite(mw_s), .halted(halted_s)
  );

  assign obs_h = {immsrc_h, alusrca_h, alusrcb_h, resultsrc_h, aluc_h, adrsrc_h,
                  ir_h, pc_h, rw_h, mw_h, halted_h};
  assign obs_s = {immsrc_s, alusrca_s, alusrcb_s, resultsrc_s, aluc_s, adrsrc_s,
                  ir_s, pc_s, rw_s, mw_s, halted_s};

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Negative argument = field not specified for that cycle
  function automatic cyc_t mk(int imm = -1, int a = -1, int b = -1, int res = -1,
                              int alu = -1, int adr = -1, bit ir = 0, bit pc = 0,
                              bit rw = 0, bit mw = 0, bit h = 0);
    cyc_t c;
    c = '0;
    if (imm >= 0) begin c.v.immsrc    = imm[1:0]; c.care[0] = 1'b1; end
    if (a   >= 0) begin c.v.alusrca   = a[1:0];   c.care[1] = 1'b1; end
    if (b   >= 0) begin c.v.alusrcb   = b[1:0];   c.care[2] = 1'b1; end
    if (res >= 0) begin c.v.resultsrc = res[1:0]; c.care[3] = 1'b1; end
    if (alu >= 0) begin c.v.aluc      = alu[2:0]; c.care[4] = 1'b1; end
    if (adr >= 0) begin c.v.adrsrc    = adr[0];   c.care[5] = 1'b1; end
    c.v.ir = ir; c.v.pc = pc; c.v.rw = rw; c.v.mw = mw; c.v.halted = h;
    return c;
  endfunction

  function automatic int alu_ref(logic [6:0] o, logic [2:0] f3, bit f7);
    case (f3)
      3'b000:  return (o == 7'b0110011 && f7) ? 1 : 0;
      3'b010:  return 5;
      3'b110:  return 3;
      3'b111:  return 2;
      default: return 0;
    endcase
  endfunction

  function automatic cyc_t fetch_e();
    return mk(.a(0), .b(2), .res(2), .alu(0), .adr(0), .ir(1), .pc(1));
  endfunction

  function automatic cyc_t reset_e();
    return mk(.a(0), .b(2), .res(2), .alu(0), .adr(0));
  endfunction

  function automatic cyc_t decode_e();
    return mk(.imm(2), .a(1), .b(1), .alu(0));
  endfunction

  function automatic void build(logic [6:0] o, logic [2:0] f3, bit f7, bit z);
    exp_q.delete();
    exp_q.push_back(fetch_e());
    exp_q.push_back(decode_e());
    case (o)
      7'b0000011: begin
        exp_q.push_back(mk(.imm(0), .a(2), .b(1), .alu(0)));
        exp_q.push_back(mk(.res(0), .adr(1)));
        exp_q.push_back(mk(.res(1), .rw(1)));
      end
      7'b0100011: begin
        exp_q.push_back(mk(.imm(1), .a(2), .b(1), .alu(0)));
        exp_q.push_back(mk(.res(0), .adr(1), .mw(1)));
      end
      7'b0110011: begin
        exp_q.push_back(mk(.a(2), .b(0), .alu(alu_ref(o, f3, f7))));
        exp_q.push_back(mk(.res(0), .rw(1)));
      end
      7'b0010011: begin
        exp_q.push_back(mk(.imm(0), .a(2), .b(1), .alu(alu_ref(o, f3, f7))));
        exp_q.push_back(mk(.res(0), .rw(1)));
      end
      7'b1100011: exp_q.push_back(mk(.a(2), .b(0), .alu(1), .res(0), .pc(z)));
      7'b1101111: begin
        exp_q.push_back(mk(.a(1), .b(2), .alu(0), .res(0), .pc(1)));
        exp_q.push_back(mk(.res(0), .rw(1)));
      end
      default: ;
    endcase
  endfunction

  task automatic cmp(string tag, obs_t o, cyc_t e);
    if (e.care[0]) chk({tag, ".immsrc"},    32'(o.immsrc),    32'(e.v.immsrc));
    if (e.care[1]) chk({tag, ".alusrca"},   32'(o.alusrca),   32'(e.v.alusrca));
    if (e.care[2]) chk({tag, ".alusrcb"},   32'(o.alusrcb),   32'(e.v.alusrcb));
    if (e.care[3]) chk({tag, ".resultsrc"}, 32'(o.resultsrc), 32'(e.v.resultsrc));
    if (e.care[4]) chk({tag, ".alucontrol"},32'(o.aluc),      32'(e.v.aluc));
    if (e.care[5]) chk({tag, ".adrsrc"},    32'(o.adrsrc),    32'(e.v.adrsrc));
    chk({tag, ".irwrite"},  32'(o.ir),     32'(e.v.ir));
    chk({tag, ".pcwrite"},  32'(o.pc),     32'(e.v.pc));
    chk({tag, ".regwrite"}, 32'(o.rw),     32'(e.v.rw));
    chk({tag, ".memwrite"}, 32'(o.mw),     32'(e.v.mw));
    chk({tag, ".halted"},   32'(o.halted), 32'(e.v.halted));
    chk({tag, ".one_wr"}, 32'((int'(o.ir) + int'(o.rw) + int'(o.mw)) <= 1), 32'd1);
  endtask

  // Entered at posedge+1 with both controllers in FETCH
  task automatic run_instr(string name, logic [6:0] o, logic [2:0] f3, bit f7, bit z);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    build(o, f3, f7, z);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      cmp($sformatf("%s[%0d].h", name, i), obs_h, exp_q[i]);
      cmp($sformatf("%s[%0d].s", name, i), obs_s, exp_q[i]);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_cycle(string name);
    @(negedge clk);
    cmp({name, ".h"}, obs_h, reset_e());
    cmp({name, ".s"}, obs_s, reset_e());
    @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops [6];
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    reset = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b1;
    reset_cycle("rst0");
    reset_cycle("rst1");
    #1 reset = 1'b0;

    run_instr("lw",    7'b0000011, 3'b010, 1'b0, 1'b1);
    run_instr("sw",    7'b0100011, 3'b010, 1'b1, 1'b1);
    run_instr("sub",   7'b0110011, 3'b000, 1'b1, 1'b0);
    run_instr("add",   7'b0110011, 3'b000, 1'b0, 1'b1);
    run_instr("addi",  7'b0010011, 3'b000, 1'b1, 1'b0);
    run_instr("slt",   7'b0110011, 3'b010, 1'b0, 1'b0);
    run_instr("ori",   7'b0010011, 3'b110, 1'b0, 1'b0);
    run_instr("and",   7'b0110011, 3'b111, 1'b0, 1'b0);
    run_instr("beq_t", 7'b1100011, 3'b000, 1'b0, 1'b1);
    run_instr("beq_n", 7'b1100011, 3'b000, 1'b0, 1'b0);
    run_instr("jal",   7'b1101111, 3'b000, 1'b0, 1'b1);

    for (int k = 0; k < 60; k++)
      run_instr($sformatf("rnd%0d", k), ops[$urandom_range(5)], 3'($urandom),
                1'($urandom), 1'($urandom));

    // Reset landing mid-load in MEMADR aborts it
    op = 7'b0000011; funct3 = 3'b010; zero = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    reset_cycle("rst_mid");
    #1 reset = 1'b0;
    run_instr("after_rst", 7'b0100011, 3'b010, 1'b0, 1'b1);

    // Illegal opcode: dut_h parks in HALT, dut_s keeps skipping
    op = 7'b1111111; zero = 1'b1;
    @(negedge clk);
    cmp("ill_f.h", obs_h, fetch_e()); cmp("ill_f.s", obs_s, fetch_e());
    @(posedge clk); #1;
    @(negedge clk);
    cmp("ill_d.h", obs_h, decode_e()); cmp("ill_d.s", obs_s, decode_e());
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cmp($sformatf("halt%0d.h", i), obs_h, mk(.h(1)));
      cmp($sformatf("skip%0d.s", i), obs_s, (i % 2 == 0) ? fetch_e() : decode_e());
      @(posedge clk); #1;
    end
    reset = 1'b1;
    reset_cycle("rst_halt");
    #1 reset = 1'b0;
    run_instr("recover", 7'b0000011, 3'b010, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
